// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle between the masters, the selected slave and the arbiter.
// The master modport drives requests and slave status; the slave modport is the arbiter view.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] HREQ;
    logic [N_MASTERS-1:0] HLOCK;
    logic                 HREADY;
    logic [1:0]           HRESP;
    logic [N_MASTERS-1:0] HGRANT;
    logic [MW-1:0]        HMASTER;
    logic                 HMASTLOCK;

    modport master (
        output HREQ, HLOCK, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HREQ, HLOCK, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with locked transfers and a maximum-tenure limit.
// Ownership only changes on HREADY-high edges; all outputs come straight from flops.
module bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  logic          CLK,
    input  logic          RST,
    bus_arbiter_if.slave  bus
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]        master_q, master_d;
    logic                 lock_q, lock_d;

    logic                 arb_s;
    logic                 any_req_s;
    logic                 other_req_s;
    logic                 err_s;
    logic [MW-1:0]        winner_s;

    function automatic logic [N_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The owner sits at the end of the scan, so it only wins when nobody else asks.
    function automatic logic [MW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [MW-1:0]        owner);
        logic [MW-1:0] pick;
        logic [MW-1:0] ci;
        logic          found;
        int            cand;
        pick  = owner;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = (int'(owner) + i) % N_MASTERS;
            ci   = MW'(cand);
            if (!found && req[ci]) begin
                pick  = ci;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration-point detection and winner selection.
    always_comb begin
        any_req_s   = |bus.HREQ;
        other_req_s = |(bus.HREQ & ~grant_q);
        err_s       = (bus.HRESP == 2'b01);
        winner_s    = rr_pick(bus.HREQ, master_q);
        arb_s       = 1'b0;
        case (state_q)
            PARK:    arb_s = 1'b1;
            OWNED:   arb_s = !bus.HREQ[master_q] || ((cnt_q == MAX_CNT) && other_req_s);
            LOCKED:  arb_s = !bus.HREQ[master_q] || !bus.HLOCK[master_q];
            default: arb_s = 1'b1;
        endcase
        if (err_s) begin
            arb_s = 1'b1;
        end else begin
            arb_s = arb_s;
        end
    end

    // Next state, grant and tenure counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        master_d = master_q;
        lock_d   = lock_q;
        if (bus.HREADY) begin
            if (arb_s) begin
                cnt_d = '0;
                if (any_req_s) begin
                    master_d = winner_s;
                    grant_d  = onehot(winner_s);
                    lock_d   = bus.HLOCK[winner_s];
                    state_d  = bus.HLOCK[winner_s] ? LOCKED : OWNED;
                end else begin
                    master_d = DEF_IDX;
                    grant_d  = onehot(DEF_IDX);
                    lock_d   = 1'b0;
                    state_d  = PARK;
                end
            end else if (state_q == OWNED && cnt_q != MAX_CNT) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; synchronous reset parks on the default master.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= PARK;
            cnt_q    <= '0;
            grant_q  <= onehot(DEF_IDX);
            master_q <= DEF_IDX;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            lock_q   <= lock_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = lock_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each stimulus cycle queues its hand-computed
// expected outputs, and a monitor compares them one clock edge later.
module tb_bus_arbiter;
    logic CLK;
    logic RST;

    bus_arbiter_if #(.N_MASTERS(4)) bif ();

    bus_arbiter #(
        .N_MASTERS(4),
        .DEFAULT_MASTER(0),
        .MAX_HOLD(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bif.slave)
    );

    typedef struct {
        logic       chk;
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; the expectation is for the state after the next rising edge.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic rdy, input logic [1:0] resp, input logic chk,
                       input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        @(negedge CLK);
        RST        = rst;
        bif.HREQ   = req;
        bif.HLOCK  = lock;
        bif.HREADY = rdy;
        bif.HRESP  = resp;
        e.chk = chk;
        e.g   = eg;
        e.m   = em;
        e.l   = el;
        e.id  = step_id;
        exp_q.push_back(e);
        step_id++;
    endtask

    // Monitor: pop one expectation per rising edge and compare the registered outputs.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) begin
                    checks++;
                    if ({bif.HGRANT, bif.HMASTER, bif.HMASTLOCK} !== {mon_e.g, mon_e.m, mon_e.l}) begin
                        errors++;
                        $display("FAIL step %0d grant/master/lock got %b/%0d/%b expected %b/%0d/%b",
                                 mon_e.id, bif.HGRANT, bif.HMASTER, bif.HMASTLOCK,
                                 mon_e.g, mon_e.m, mon_e.l);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RST        = 1'b1;
        bif.HREQ   = 4'b0000;
        bif.HLOCK  = 4'b0000;
        bif.HREADY = 1'b1;
        bif.HRESP  = 2'b00;

        // Reset, then idle parking on master 0.
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 4'b0001, 2'd0, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Rotation: 0110 from park picks 1, then 2, then back to park.
        cyc(1'b0, 4'b0110, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0010, 2'd1, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // HREADY low in park blocks a new grant.
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Tenure limit: master 2 granted, 8 counting edges, handover on the 9th.
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 4'b1100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc(1'b0, 4'b1100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Same limit with three HREADY-low cycles (one carrying ERROR) delays handover by 3.
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i == 2 || i == 5 || i == 7)
                cyc(1'b0, 4'b1100, 4'b0000, 1'b0, (i == 5) ? 2'b01 : 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
            else
                cyc(1'b0, 4'b1100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);
        end
        cyc(1'b0, 4'b1100, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Locked tenure ignores competitors and the tenure limit.
        cyc(1'b0, 4'b1111, 4'b0010, 1'b1, 2'b00, 1'b1, 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 4'b1111, 4'b0010, 1'b1, 2'b00, 1'b1, 4'b0010, 2'd1, 1'b1);
        cyc(1'b0, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b0);

        // ERROR terminates a lock only when HREADY is high.
        cyc(1'b0, 4'b0010, 4'b0010, 1'b1, 2'b00, 1'b1, 4'b0010, 2'd1, 1'b1);
        cyc(1'b0, 4'b0011, 4'b0010, 1'b0, 2'b01, 1'b1, 4'b0010, 2'd1, 1'b1);
        cyc(1'b0, 4'b0011, 4'b0010, 1'b1, 2'b01, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0010, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Reset aborts a locked tenure of master 3.
        cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b1);
        cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b1);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0);

        @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
